// File: rtl/hwpe_ctrl_periph2reqrsp.sv
// ---------------------------------------------------------------------------
// hwpe_ctrl_periph2reqrsp
//
// Bridges a peripheral-style control port (req/gnt request, r_valid/r_id
// response) onto a reqrsp target (valid/ready on both request and response).
// reqrsp carries no transaction ID, so each accepted periph ID is queued in a
// small in-order FIFO and handed back with the matching response beat.
// Responses are registered toward the periph side because periph has no
// r_ready and must never be stalled.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   periph_req_i/gnt_o      periph request handshake
//   periph_add_i            request address
//   periph_wen_i            1 = read, 0 = write
//   periph_be_i/data_i      byte enables / write data
//   periph_id_i             request transaction ID
//   periph_r_data_o         registered response data
//   periph_r_valid_o        one-cycle response pulse
//   periph_r_id_o           ID of the request this response belongs to
//   q_addr_o/write_o/strb_o/data_o   reqrsp request payload
//   q_valid_o/q_ready_i     reqrsp request handshake
//   p_data_i                reqrsp response data
//   p_valid_i/p_ready_o     reqrsp response handshake
//   outst_o                 number of requests awaiting a response
// ---------------------------------------------------------------------------
module hwpe_ctrl_periph2reqrsp #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned IW        = 8,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,

    input  logic                           periph_req_i,
    output logic                           periph_gnt_o,
    input  logic [AW-1:0]                  periph_add_i,
    input  logic                           periph_wen_i,
    input  logic [DW/8-1:0]                periph_be_i,
    input  logic [DW-1:0]                  periph_data_i,
    input  logic [IW-1:0]                  periph_id_i,
    output logic [DW-1:0]                  periph_r_data_o,
    output logic                           periph_r_valid_o,
    output logic [IW-1:0]                  periph_r_id_o,

    output logic [AW-1:0]                  q_addr_o,
    output logic                           q_write_o,
    output logic [DW/8-1:0]                q_strb_o,
    output logic [DW-1:0]                  q_data_o,
    output logic                           q_valid_o,
    input  logic                           q_ready_i,

    input  logic [DW-1:0]                  p_data_i,
    input  logic                           p_valid_i,
    output logic                           p_ready_o,

    output logic [$clog2(MAX_OUTST+1)-1:0] outst_o
);

    localparam int unsigned CW = $clog2(MAX_OUTST + 1);
    localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTST);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTST - 1);

    logic [CW-1:0] outst;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] id_mem [MAX_OUTST];
    logic          not_full;
    logic          push;
    logic          pop;

    // Pointers wrap at MAX_OUTST, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    // Request path is pure wiring. Fullness uses only the registered count,
    // so a response popping this cycle does not free a slot until the next.
    assign q_addr_o     = periph_add_i;
    assign q_write_o    = ~periph_wen_i;
    assign q_strb_o     = periph_be_i;
    assign q_data_o     = periph_data_i;

    assign not_full     = (outst != FULL_CNT);
    assign q_valid_o    = periph_req_i & not_full;
    assign periph_gnt_o = q_valid_o & q_ready_i;
    assign push         = periph_gnt_o;

    // Only accept a response when something is actually outstanding.
    assign p_ready_o    = (outst != '0);
    assign pop          = p_valid_i & p_ready_o;

    assign outst_o      = outst;

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= periph_id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst            <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            periph_r_valid_o <= 1'b0;
            periph_r_data_o  <= '0;
            periph_r_id_o    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr          <= next_ptr(rd_ptr);
                periph_r_data_o <= p_data_i;
                periph_r_id_o   <= id_mem[rd_ptr];
            end
            periph_r_valid_o <= pop;

            case ({push, pop})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: outst <= outst;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A response beat with nothing outstanding means the target is out of
    // step with the bridge (e.g. it was not reset together with it).
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(p_valid_i && (outst == '0)))
        else $error("response beat with no outstanding request");

    assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && (outst == FULL_CNT)))
        else $error("request accepted while ID FIFO full");
`endif

endmodule

// File: tb/tb_hwpe_ctrl_periph2reqrsp.sv
// ---------------------------------------------------------------------------
// tb_hwpe_ctrl_periph2reqrsp
//
// The bench plays both the periph master and the reqrsp target. A capture
// process, running mid-cycle, checks the combinational request path against
// a queue-based model (the model's queue length is the outstanding count)
// and records what will happen at the coming edge: accepted IDs are queued,
// and every response beat pushes its expected {data, id} pair onto the
// scoreboard. A separate monitor pops the scoreboard whenever r_valid shows.
// ---------------------------------------------------------------------------
module tb_hwpe_ctrl_periph2reqrsp;

    localparam int MAX = 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  id;
    logic [31:0] r_data;
    logic        r_valid;
    logic [7:0]  r_id;
    logic [31:0] q_addr;
    logic        q_write;
    logic [3:0]  q_strb;
    logic [31:0] q_data;
    logic        q_valid;
    logic        q_ready;
    logic [31:0] p_data;
    logic        p_valid;
    logic        p_ready;
    logic [2:0]  outst;

    hwpe_ctrl_periph2reqrsp #(
        .AW(32), .DW(32), .IW(8), .MAX_OUTST(MAX)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .periph_req_i     (req),
        .periph_gnt_o     (gnt),
        .periph_add_i     (add),
        .periph_wen_i     (wen),
        .periph_be_i      (be),
        .periph_data_i    (data),
        .periph_id_i      (id),
        .periph_r_data_o  (r_data),
        .periph_r_valid_o (r_valid),
        .periph_r_id_o    (r_id),
        .q_addr_o         (q_addr),
        .q_write_o        (q_write),
        .q_strb_o         (q_strb),
        .q_data_o         (q_data),
        .q_valid_o        (q_valid),
        .q_ready_i        (q_ready),
        .p_data_i         (p_data),
        .p_valid_i        (p_valid),
        .p_ready_o        (p_ready),
        .outst_o          (outst)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    logic [7:0]  id_q[$];     // IDs accepted and not yet answered
    int          tgt_q[$];    // cycle at which each pending request may be answered
    logic [31:0] exp_d[$];
    logic [7:0]  exp_id[$];
    logic        rv_exp = 1'b0;

    // Target controls
    logic        tgt_en     = 1'b0;
    int          tgt_lat    = 1;
    logic        fixed_en   = 1'b0;
    logic [31:0] fixed_data = '0;

    logic        do_pop;
    logic        do_acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((id_q.size() != 0 || exp_d.size() != 0) && k < budget) begin
            cyc_step();
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_errors++;
            $display("FAIL drain_timeout: %0d still outstanding after %0d cycles", id_q.size(), budget);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // reqrsp target: answers in order, no earlier than tgt_lat cycles after accept
    initial begin
        p_valid = 1'b0;
        p_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && tgt_en && tgt_q.size() != 0 && tgt_q[0] <= cyc) begin
                p_valid = 1'b1;
                p_data  = fixed_en ? fixed_data : $urandom;
            end else begin
                p_valid = 1'b0;
            end
        end
    end

    // Capture: mid-cycle check of the combinational path, then model update
    initial begin
        forever begin
            @(negedge clk);
            chk("q_valid", 64'(q_valid), 64'(req && (id_q.size() < MAX)));
            chk("gnt",     64'(gnt),     64'(req && q_ready && (id_q.size() < MAX)));
            chk("p_ready", 64'(p_ready), 64'(id_q.size() != 0));
            chk("outst",   64'(outst),   64'(id_q.size()));
            chk("q_addr",  64'(q_addr),  64'(add));
            chk("q_ctl",   64'({q_write, q_strb}), 64'({~wen, be}));
            chk("q_data",  64'(q_data),  64'(data));
            if (rst) begin
                id_q.delete();
                tgt_q.delete();
                exp_d.delete();
                exp_id.delete();
                rv_exp = 1'b0;
            end else begin
                do_pop = p_valid && p_ready;
                do_acc = req && gnt;
                if (do_pop && id_q.size() != 0) begin
                    exp_d.push_back(p_data);
                    exp_id.push_back(id_q.pop_front());
                    if (tgt_q.size() != 0) void'(tgt_q.pop_front());
                end
                if (do_acc) begin
                    id_q.push_back(id);
                    tgt_q.push_back(cyc + tgt_lat);
                end
                rv_exp = do_pop;
            end
        end
    end

    // Monitor: registered response side, just after each edge
    initial begin
        forever begin
            @(posedge clk);
            #3;
            chk("r_valid", 64'(r_valid), 64'(rv_exp));
            if (r_valid) begin
                if (exp_d.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL r_unexpected: response id %0h with empty scoreboard", r_id);
                end else begin
                    chk("r_data", 64'(r_data), 64'(exp_d.pop_front()));
                    chk("r_id",   64'(r_id),   64'(exp_id.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_total;
        int run;
        int max_run;

        rst = 1'b1; req = 1'b0; add = '0; wen = 1'b1; be = 4'hF; data = '0; id = '0; q_ready = 1'b1;
        repeat (3) cyc_step();
        rst = 1'b0;
        #1;
        chk("rst_outst",   64'(outst),   64'd0);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_r_data",  64'(r_data),  64'd0);
        chk("rst_r_id",    64'(r_id),    64'd0);
        chk("rst_p_ready", 64'(p_ready), 64'd0);
        chk("rst_gnt",     64'(gnt),     64'd0);
        cyc_step();

        // 1: single read
        wen = 1'b1; id = 8'h5A; add = 32'h1000_0040; q_ready = 1'b1;
        tgt_lat = 2; fixed_en = 1'b1; fixed_data = 32'hDEAD_BEEF; tgt_en = 1'b1;
        req = 1'b1;
        #1 chk("t1_gnt", 64'(gnt), 64'd1);
        cyc_step();
        req = 1'b0;
        wait_idle(20);
        chk("t1_r_data", 64'(r_data), 64'hDEAD_BEEF);
        chk("t1_r_id",   64'(r_id),   64'h5A);
        fixed_en = 1'b0;

        // 2: write
        wen = 1'b0; be = 4'b0011; data = 32'h1234; id = 8'hA7; req = 1'b1;
        #1;
        chk("t2_q_write", 64'(q_write), 64'd1);
        chk("t2_q_strb",  64'(q_strb),  64'h3);
        chk("t2_q_data",  64'(q_data),  64'h1234);
        cyc_step();
        req = 1'b0;
        wait_idle(20);
        chk("t2_r_id",  64'(r_id),  64'hA7);
        chk("t2_outst", 64'(outst), 64'd0);

        // 3: fill to MAX, the fifth request waits until the cycle after a pop
        tgt_en = 1'b0; tgt_lat = 1; q_ready = 1'b1; wen = 1'b1; be = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            id = 8'(i); req = 1'b1;
            #3 chk("t3_gnt", 64'(gnt), 64'd1);
            cyc_step();
        end
        id = 8'd5;
        #3;
        chk("t3_full_gnt",   64'(gnt),     64'd0);
        chk("t3_full_qv",    64'(q_valid), 64'd0);
        chk("t3_full_outst", 64'(outst),   64'd4);
        cyc_step();
        tgt_en = 1'b1;
        #3;
        chk("t3_pop_p_valid", 64'(p_valid), 64'd1);
        chk("t3_nobypass",    64'(gnt),     64'd0);
        cyc_step();
        tgt_en = 1'b0;
        #3;
        chk("t3_after_gnt",   64'(gnt),   64'd1);
        chk("t3_after_outst", 64'(outst), 64'd3);
        cyc_step();
        req = 1'b0;
        #3 chk("t3_outst_back", 64'(outst), 64'd4);
        tgt_en = 1'b1;
        wait_idle(30);

        // 4: eight back-to-back reads, latency 1 -> eight consecutive responses
        tgt_lat = 1; tgt_en = 1'b1; q_ready = 1'b1; wen = 1'b1;
        rv_total = 0; run = 0; max_run = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < 8) begin
                req = 1'b1; id = 8'h10 + 8'(k); add = $urandom;
            end else begin
                req = 1'b0;
            end
            #3;
            if (r_valid) begin
                rv_total++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            cyc_step();
        end
        chk("t4_rv_total", 64'(rv_total), 64'd8);
        chk("t4_rv_run",   64'(max_run),  64'd8);
        wait_idle(20);

        // 5: backpressure
        q_ready = 1'b0; req = 1'b1; wen = 1'b1; id = 8'h33;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("t5_gnt",     64'(gnt),     64'd0);
            chk("t5_q_valid", 64'(q_valid), 64'd1);
            chk("t5_outst",   64'(outst),   64'd0);
            cyc_step();
        end
        q_ready = 1'b1;
        #3 chk("t5_release_gnt", 64'(gnt), 64'd1);
        cyc_step();
        req = 1'b0;
        wait_idle(20);

        // 6: reset with three requests in flight
        tgt_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req = 1'b1; id = 8'hC0 + 8'(k);
            cyc_step();
        end
        req = 1'b0;
        #1 chk("t6_pre_outst", 64'(outst), 64'd3);
        rst = 1'b1;
        cyc_step();
        rst = 1'b0;
        #1;
        chk("t6_outst",   64'(outst),   64'd0);
        chk("t6_r_valid", 64'(r_valid), 64'd0);
        chk("t6_p_ready", 64'(p_ready), 64'd0);
        chk("t6_r_data",  64'(r_data),  64'd0);
        chk("t6_r_id",    64'(r_id),    64'd0);
        tgt_en = 1'b1;
        cyc_step();
        cyc_step();
        chk("t6_idle_p_ready", 64'(p_ready), 64'd0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            req     = ($urandom_range(0, 3) != 0);
            wen     = $urandom_range(0, 1);
            id      = 8'($urandom);
            add     = $urandom;
            be      = 4'($urandom);
            data    = $urandom;
            q_ready = ($urandom_range(0, 3) != 0);
            tgt_en  = ($urandom_range(0, 2) != 0);
            tgt_lat = $urandom_range(1, 3);
            cyc_step();
        end
        req = 1'b0; tgt_en = 1'b1;
        wait_idle(100);
        cyc_step();
        chk("final_outst", 64'(outst), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
